cpu_io_dispatch: RTL and testbench

CPU_IO_DISPATCH -- requirements
Module: cpu_io_dispatch

---
 rtl/cpu_io_dispatch_pkg.sv | 24 ++
 rtl/cpu_io_dispatch.sv | 91 +++++++++
 tb/tb_cpu_io_dispatch.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_io_dispatch_pkg.sv
// Shared constants for the CPU I/O dispatcher: function codes, FSM state encoding
// and the condition codes returned for rejected requests.
package cpu_io_dispatch_pkg;

    localparam logic [2:0] FNC_SIO = 3'd0;
    localparam logic [2:0] FNC_TIO = 3'd1;
    localparam logic [2:0] FNC_TDV = 3'd2;
    localparam logic [2:0] FNC_HIO = 3'd3;
    localparam logic [2:0] FNC_AIO = 3'd6;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [1:0] CC_ILLEGAL_FUNC = 2'b11;
    localparam logic [1:0] CC_NO_IOP       = 2'b10;

    function automatic logic func_legal(input logic [2:0] f);
        return (f == FNC_SIO) || (f == FNC_TIO) || (f == FNC_TDV) ||
               (f == FNC_HIO) || (f == FNC_AIO);
    endfunction

endpackage

// File: rtl/cpu_io_dispatch.sv
// Dispatches one CPU I/O request to an IOP: setup cycle, timed memory-bus grant, completion pulse.
// Optional IOP-number range check is enabled by defining IO_ADDR_CHECK_EN.
module cpu_io_dispatch #(
    parameter int HOLD_CYCLES = 4,
    parameter int NUM_IOPS    = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [0:2]    func,
    input  logic [21:31]  device,
    output logic          busy,
    output logic          done,
    output logic [0:1]    cc,
    output logic          cpu_mem_en,
    output logic          iop_active,
    output logic [0:2]    iop_func,
    output logic [21:31]  iop_device,
    input  logic [0:1]    iop_cc,
    output logic [1:0]    dbg_state
);
    import cpu_io_dispatch_pkg::*;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

`ifdef IO_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    logic [1:0] state;
    logic [3:0] count;
    logic       func_ok;
    logic       iop_ok;

    assign func_ok = func_legal(func);
    assign iop_ok  = !ADDR_CHECK || (32'(device[21:23]) < NUM_IOPS);

    // Handshake: start is sampled only while busy is low; a start seen while busy is dropped, never queued.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= 4'd0;
            cc         <= 2'b00;
            iop_func   <= 3'd0;
            iop_device <= 11'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (!func_ok) begin
                            cc    <= CC_ILLEGAL_FUNC;
                            state <= ST_DONE;
                        end else if (!iop_ok) begin
                            cc    <= CC_NO_IOP;
                            state <= ST_DONE;
                        end else begin
                            iop_func   <= func;
                            iop_device <= device;
                            state      <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    count <= HOLD_LOAD;
                    state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    // The grant ends on the edge where the counter has run out; the IOP's cc is taken then.
                    if (count == 4'd0) begin
                        cc    <= iop_cc;
                        state <= ST_DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Decoded from state so an asynchronous reset drops the grant immediately.
    assign iop_active = (state == ST_ACTIVE);
    assign cpu_mem_en = ~iop_active;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign dbg_state  = state;

endmodule

// File: tb/tb_cpu_io_dispatch.sv
// Self-checking bench for cpu_io_dispatch: two instances (HOLD_CYCLES 4 and 1) driven from
// directed and random requests, checked against a transaction-level reference model.
module tb_cpu_io_dispatch;
    import cpu_io_dispatch_pkg::*;

    localparam int NUM_IOPS = 1;
`ifdef IO_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        sel;
    logic [2:0]  func;
    logic [10:0] device;
    logic [1:0]  iop_cc;

    logic        start0, start1;
    logic        busy0, done0, mem_en0, active0, busy1, done1, mem_en1, active1;
    logic [1:0]  cc0, cc1, dbg0, dbg1;
    logic [2:0]  ifunc0, ifunc1;
    logic [10:0] idev0, idev1;

    logic        o_busy, o_done, o_mem_en, o_active;
    logic [1:0]  o_cc;
    logic [2:0]  o_ifunc;
    logic [10:0] o_idev;

    int checks = 0;
    int errors = 0;
    logic [2:0]  exp_if[2];
    logic [10:0] exp_id[2];

    always #5 clock = ~clock;

    assign start0 = start & ~sel;
    assign start1 = start & sel;

    assign o_busy   = sel ? busy1   : busy0;
    assign o_done   = sel ? done1   : done0;
    assign o_mem_en = sel ? mem_en1 : mem_en0;
    assign o_active = sel ? active1 : active0;
    assign o_cc     = sel ? cc1     : cc0;
    assign o_ifunc  = sel ? ifunc1  : ifunc0;
    assign o_idev   = sel ? idev1   : idev0;

    cpu_io_dispatch #(.HOLD_CYCLES(4), .NUM_IOPS(NUM_IOPS)) dut0 (
        .clock(clock), .reset(reset), .start(start0), .func(func), .device(device),
        .busy(busy0), .done(done0), .cc(cc0), .cpu_mem_en(mem_en0), .iop_active(active0),
        .iop_func(ifunc0), .iop_device(idev0), .iop_cc(iop_cc), .dbg_state(dbg0)
    );

    cpu_io_dispatch #(.HOLD_CYCLES(1), .NUM_IOPS(NUM_IOPS)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .func(func), .device(device),
        .busy(busy1), .done(done1), .cc(cc1), .cpu_mem_en(mem_en1), .iop_active(active1),
        .iop_func(ifunc1), .iop_device(idev1), .iop_cc(iop_cc), .dbg_state(dbg1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a rejected request returns its code (never 0); 0 means the request is legal.
    function automatic logic [1:0] exp_reject(input logic [2:0] f, input logic [10:0] dev);
        if (f == 3'd4 || f == 3'd5 || f == 3'd7) return 2'b11;
        if (ADDR_CHECK && int'(dev[10:8]) >= NUM_IOPS) return 2'b10;
        return 2'b00;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic [2:0] f, input logic [10:0] dev, input bit mid_start,
                          input int fixed_cc, input string tag);
        int hold, active_n, first_k, done_n, done_k, addr_bad, memen_bad;
        bit fin, legal;
        logic [1:0]  rej, cc_seen, exp_cc;
        logic [1:0]  drv[0:63];
        logic [2:0]  ifunc_done;
        logic [10:0] idev_done;
        int d;
        hold = sel ? 1 : 4;
        d = sel ? 1 : 0;
        rej = exp_reject(f, dev);
        legal = (rej == 2'b00);
        active_n = 0; first_k = -1; done_n = 0; done_k = -1; addr_bad = 0; memen_bad = 0;
        fin = 1'b0; cc_seen = 2'b00; ifunc_done = 3'd0; idev_done = 11'd0;
        start = 1'b1; func = f; device = dev;
        iop_cc = (fixed_cc >= 0) ? 2'(fixed_cc) : 2'($urandom_range(0, 3));
        for (int k = 0; k < 40 && !fin; k++) begin
            @(negedge clock);
            start = mid_start && (k == 2);
            if (o_active) begin
                active_n++;
                if (first_k < 0) first_k = k;
                if (o_idev !== dev || o_ifunc !== f) addr_bad++;
            end
            if (o_mem_en !== ~o_active) memen_bad++;
            if (o_done) begin
                done_n++; done_k = k; cc_seen = o_cc; ifunc_done = o_ifunc; idev_done = o_idev;
            end
            if (done_n > 0 && !o_done && !o_busy) fin = 1'b1;
            drv[k] = (fixed_cc >= 0) ? 2'(fixed_cc) : 2'($urandom_range(0, 3));
            iop_cc = drv[k];
            func = 3'($urandom);
            device = 11'($urandom);
        end
        if (legal) begin
            exp_if[d] = f;
            exp_id[d] = dev;
            exp_cc = drv[hold];
        end else begin
            exp_cc = rej;
        end
        chk({tag, "_finished"}, 32'(fin), 1);
        chk({tag, "_done_count"}, done_n, 1);
        chk({tag, "_done_cycle"}, done_k, legal ? hold + 1 : 0);
        chk({tag, "_grant_len"}, active_n, legal ? hold : 0);
        chk({tag, "_grant_start"}, first_k, legal ? 1 : -1);
        chk({tag, "_cc"}, 32'(cc_seen), 32'(exp_cc));
        chk({tag, "_addr_stable"}, addr_bad, 0);
        chk({tag, "_mem_en"}, memen_bad, 0);
        chk({tag, "_iop_func"}, 32'(ifunc_done), 32'(exp_if[d]));
        chk({tag, "_iop_device"}, 32'(idev_done), 32'(exp_id[d]));
        if (mid_start) begin
            repeat (2) begin
                @(negedge clock);
                chk({tag, "_not_queued"}, 32'(o_busy), 0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_n;
        sel = 1'b0; start = 1'b0; func = 3'd0; device = 11'd0; iop_cc = 2'b00; reset = 1'b1;
        exp_if[0] = 3'd0; exp_if[1] = 3'd0; exp_id[0] = 11'd0; exp_id[1] = 11'd0;
        repeat (2) @(negedge clock);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_cc", 32'(cc0), 0);
        chk("rst_active", 32'(active0), 0);
        chk("rst_mem_en", 32'(mem_en0), 1);
        chk("rst_iop_func", 32'(ifunc0), 0);
        chk("rst_iop_device", 32'(idev0), 0);
        chk("rst_state0", 32'(dbg0), 32'(ST_IDLE));
        chk("rst_state1", 32'(dbg1), 32'(ST_IDLE));
        reset = 1'b0;
        @(negedge clock);

        run_op(3'd0, 11'h003, 1'b0, 1, "sio_basic");
        run_op(3'd5, 11'h7ff, 1'b0, -1, "illegal_f5");
        run_op(3'd1, 11'h0a5, 1'b1, -1, "mid_start");
        run_op(3'd0, 11'h101, 1'b0, -1, "iop_num_1");
        run_op(3'd7, 11'h010, 1'b0, -1, "illegal_f7");
        run_op(3'd6, 11'h0ff, 1'b0, -1, "aio");
        for (int i = 0; i < 12; i++)
            run_op(3'($urandom), 11'($urandom), 1'($urandom), -1, "rand4");

        // Reset landing in the second grant cycle.
        start = 1'b1; func = 3'd2; device = 11'h055;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_mid_pre_active", 32'(active0), 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_active", 32'(active0), 0);
        chk("rst_mid_mem_en", 32'(mem_en0), 1);
        chk("rst_mid_busy", 32'(busy0), 0);
        chk("rst_mid_done", 32'(done0), 0);
        chk("rst_mid_cc", 32'(cc0), 0);
        chk("rst_mid_device", 32'(idev0), 0);
        exp_if[0] = 3'd0; exp_if[1] = 3'd0; exp_id[0] = 11'd0; exp_id[1] = 11'd0;
        @(negedge clock);
        reset = 1'b0;
        done_n = 0;
        repeat (8) begin
            @(negedge clock);
            if (done0) done_n++;
        end
        chk("rst_mid_no_done", done_n, 0);
        chk("rst_mid_cc_after", 32'(cc0), 0);

        sel = 1'b1;
        run_op(3'd1, 11'h002, 1'b0, -1, "h1_tio");
        run_op(3'd3, 11'h004, 1'b0, -1, "h1_hio");
        for (int i = 0; i < 6; i++)
            run_op(3'($urandom), 11'($urandom), 1'b0, -1, "rand1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
